pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl_if.sv | 31 +++
 rtl/pc_redirect_ctrl.sv | 92 +++++++++
 tb/tb_pc_redirect_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_ctrl_if.sv
// Branch/jump resolution inputs and fetch-redirect outputs of the PC redirect controller.
// The master modport is the pipeline side and the slave modport is the controller.
interface pc_redirect_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             br_valid;
   logic             br_taken;
   logic [31:0]      br_target;
   logic             jmp_valid;
   logic [31:0]      jmp_target;
   logic             stall_in;
   logic [31:0]      branch_pc;
   logic             npc_control;
   logic             flush_if;
   logic             flush_dec;
   logic             flush_exec;
   logic             misalign_err;
   logic [CNT_W-1:0] redirect_cnt;

   modport master (
      output br_valid, br_taken, br_target, jmp_valid, jmp_target, stall_in,
      input  branch_pc, npc_control, flush_if, flush_dec, flush_exec,
             misalign_err, redirect_cnt
   );

   modport slave (
      input  br_valid, br_taken, br_target, jmp_valid, jmp_target, stall_in,
      output branch_pc, npc_control, flush_if, flush_dec, flush_exec,
             misalign_err, redirect_cnt
   );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: Mem-stage branch/jump resolution to a one-cycle fetch redirect and flush, 1-cycle latency.
// stall_in defers resolution in IDLE and freezes the wrong-path shadow window; there is no other backpressure.
module pc_redirect_ctrl #(
   parameter int SHADOW_CYCLES = 3,
   parameter int CNT_W         = 16
) (
   input  logic                clk,
   input  logic                rst,
   pc_redirect_ctrl_if.slave   bus
);
   localparam int SC_W = $clog2(SHADOW_CYCLES + 1);

   typedef enum logic {IDLE, SHADOW} state_t;

   state_t           state_q, state_d;
   logic [SC_W-1:0]  sc_q, sc_d;
   logic             redirect_ev;
   logic [31:0]      sel_target;

   logic             npc_q;
   logic             flush_q;
   logic [31:0]      pc_q;
   logic             mis_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sc_q    <= '0;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
      end
   end

   // Jump wins over a simultaneous branch; resolutions only count in IDLE.
   always_comb begin
      sel_target  = bus.jmp_valid ? bus.jmp_target : bus.br_target;
      redirect_ev = 1'b0;
      state_d     = state_q;
      sc_d        = sc_q;
      case (state_q)
         IDLE: begin
            if ((bus.jmp_valid | (bus.br_valid & bus.br_taken)) & ~bus.stall_in) begin
               redirect_ev = 1'b1;
               state_d     = SHADOW;
               sc_d        = SC_W'(SHADOW_CYCLES);
            end
         end
         SHADOW: begin
            if (!bus.stall_in) begin
               sc_d = sc_q - SC_W'(1);
               if (sc_q == SC_W'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         npc_q   <= 1'b0;
         flush_q <= 1'b0;
         pc_q    <= 32'h0;
         mis_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         npc_q   <= redirect_ev;
         flush_q <= redirect_ev;
         if (redirect_ev) begin
            pc_q <= {sel_target[31:2], 2'b00};
         end
         if (redirect_ev && (sel_target[1:0] != 2'b00)) begin
            mis_q <= 1'b1;
         end
         // Saturate rather than wrap so software never sees a small bogus count.
         if (redirect_ev && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.npc_control  = npc_q;
   assign bus.flush_if     = flush_q;
   assign bus.flush_dec    = flush_q;
   assign bus.flush_exec   = flush_q;
   assign bus.branch_pc    = pc_q;
   assign bus.misalign_err = mis_q;
   assign bus.redirect_cnt = cnt_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed vectors plus hand-written reset/saturation sequences for pc_redirect_ctrl.
module tb_pc_redirect_ctrl;
   localparam int CNT_W = 4;
   localparam int NV    = 26;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   pc_redirect_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pc_redirect_ctrl #(.SHADOW_CYCLES(3), .CNT_W(CNT_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        bv;
      logic        bt;
      logic [31:0] bta;
      logic        jv;
      logic [31:0] jta;
      logic        st;
      logic        e_npc;
      logic [31:0] e_pc;
      logic        e_mis;
      int          e_cnt;
   } vec_t;

   vec_t tbl [NV];

   function automatic vec_t mk(logic bv, logic bt, logic [31:0] bta, logic jv,
                               logic [31:0] jta, logic st, logic e_npc,
                               logic [31:0] e_pc, logic e_mis, int e_cnt);
      vec_t v;
      v.bv = bv; v.bt = bt; v.bta = bta; v.jv = jv; v.jta = jta; v.st = st;
      v.e_npc = e_npc; v.e_pc = e_pc; v.e_mis = e_mis; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic e_npc, input logic [31:0] e_pc,
                          input logic e_mis, input int e_cnt);
      chk({tag, ".npc_control"}, {31'b0, bus.npc_control}, {31'b0, e_npc});
      chk({tag, ".flush_if"},    {31'b0, bus.flush_if},    {31'b0, e_npc});
      chk({tag, ".flush_dec"},   {31'b0, bus.flush_dec},   {31'b0, e_npc});
      chk({tag, ".flush_exec"},  {31'b0, bus.flush_exec},  {31'b0, e_npc});
      chk({tag, ".branch_pc"},   bus.branch_pc,            e_pc);
      chk({tag, ".misalign_err"}, {31'b0, bus.misalign_err}, {31'b0, e_mis});
      chk({tag, ".redirect_cnt"}, {{(32-CNT_W){1'b0}}, bus.redirect_cnt}, e_cnt);
   endtask

   task automatic drive(input logic bv, input logic bt, input logic [31:0] bta,
                        input logic jv, input logic [31:0] jta, input logic st);
      bus.br_valid = bv; bus.br_taken = bt; bus.br_target = bta;
      bus.jmp_valid = jv; bus.jmp_target = jta; bus.stall_in = st;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] e_pc;
      int          e_cnt;

      // Main table: rows 2..6 redirect + shadow, 10..11 stall deferral,
      // 12..17 stall-stretched shadow, 21 priority/misalign.
      tbl[0]  = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h0,  0,0);
      tbl[1]  = mk(1,0,32'h80, 0,32'h0,  0, 0,32'h0,  0,0);
      tbl[2]  = mk(1,1,32'h40, 0,32'h0,  0, 1,32'h40, 0,1);
      tbl[3]  = mk(0,0,32'h0,  1,32'h300,0, 0,32'h40, 0,1);
      tbl[4]  = mk(0,0,32'h0,  1,32'h300,0, 0,32'h40, 0,1);
      tbl[5]  = mk(0,0,32'h0,  1,32'h300,0, 0,32'h40, 0,1);
      tbl[6]  = mk(0,0,32'h0,  1,32'h300,0, 1,32'h300,0,2);
      tbl[7]  = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h300,0,2);
      tbl[8]  = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h300,0,2);
      tbl[9]  = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h300,0,2);
      tbl[10] = mk(1,1,32'h500,0,32'h0,  1, 0,32'h300,0,2);
      tbl[11] = mk(1,1,32'h500,0,32'h0,  0, 1,32'h500,0,3);
      tbl[12] = mk(0,0,32'h0,  0,32'h0,  1, 0,32'h500,0,3);
      tbl[13] = mk(0,0,32'h0,  0,32'h0,  1, 0,32'h500,0,3);
      tbl[14] = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h500,0,3);
      tbl[15] = mk(1,1,32'h600,0,32'h0,  0, 0,32'h500,0,3);
      tbl[16] = mk(1,1,32'h600,0,32'h0,  0, 0,32'h500,0,3);
      tbl[17] = mk(1,1,32'h600,0,32'h0,  0, 1,32'h600,0,4);
      tbl[18] = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h600,0,4);
      tbl[19] = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h600,0,4);
      tbl[20] = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h600,0,4);
      tbl[21] = mk(1,1,32'h200,1,32'h102,0, 1,32'h100,1,5);
      tbl[22] = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h100,1,5);
      tbl[23] = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h100,1,5);
      tbl[24] = mk(0,0,32'h0,  0,32'h0,  0, 0,32'h100,1,5);
      tbl[25] = mk(0,0,32'h0,  1,32'h44, 0, 1,32'h44, 1,6);

      drive(0,0,32'h0,0,32'h0,0);
      #1;
      chk_all("reset", 0, 32'h0, 0, 0);
      step();
      step();
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].bv, tbl[i].bt, tbl[i].bta, tbl[i].jv, tbl[i].jta, tbl[i].st);
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].e_npc, tbl[i].e_pc, tbl[i].e_mis, tbl[i].e_cnt);
      end

      // Drive the counter up to all-ones, then one more redirect must not wrap.
      e_cnt = 6;
      for (int k = 0; k < 10; k++) begin
         drive(0,0,32'h0,0,32'h0,0);
         step(); step(); step();
         e_pc = 32'h1000 + 32'(k * 4);
         drive(0,0,32'h0,1,e_pc,0);
         step();
         if (e_cnt < 15) e_cnt++;
         chk_all($sformatf("sat%0d", k), 1, e_pc, 1, e_cnt);
      end

      // Reset in the middle of SHADOW: outputs clear at once, no pending redirect.
      drive(0,0,32'h0,0,32'h0,0);
      step();
      rst = 1'b1;
      #1;
      chk_all("rstA_async", 0, 32'h0, 0, 0);
      step();
      chk_all("rstA_held", 0, 32'h0, 0, 0);
      rst = 1'b0;
      step();
      chk_all("rstA_idle", 0, 32'h0, 0, 0);
      drive(0,0,32'h0,1,32'h80,0);
      step();
      chk_all("rstA_redir", 1, 32'h80, 0, 1);

      // Redirect on the very first edge after releasing a mid-SHADOW reset.
      drive(0,0,32'h0,0,32'h0,0);
      step();
      rst = 1'b1;
      #1;
      chk_all("rstB_async", 0, 32'h0, 0, 0);
      step();
      rst = 1'b0;
      drive(0,0,32'h0,1,32'h84,0);
      step();
      chk_all("rstB_first", 1, 32'h84, 0, 1);
      drive(0,0,32'h0,0,32'h0,0);
      step();
      chk_all("rstB_pulse_end", 0, 32'h84, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
